// File: rtl/rx_frame_ctrl_if.sv
// Control/status bundle between the 802.11a receive datapath and rx_frame_ctrl.
// The service port exists only when RX_SERVICE_CAPTURE_EN is defined.
interface rx_frame_ctrl_if #(
  parameter int LEN_W = 12,
  parameter int PAD_W = 8
);
  logic             start;
  logic             abort;
  logic [3:0]       rate;
  logic [LEN_W-1:0] length;
  logic             in_valid;
  logic             in_ready;
  logic             sym_start;
  logic [8:0]       n_cbps;
  logic [PAD_W-1:0] num_pads;
  logic             dec_valid;
  logic             dec_bit;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             rate_err;
`ifdef RX_SERVICE_CAPTURE_EN
  logic [15:0]      service;

  modport master (
    output start, abort, rate, length, in_valid, dec_valid, dec_bit,
    input  in_ready, sym_start, n_cbps, num_pads, out_bit, out_valid,
    input  busy, done, rate_err, service
  );

  modport slave (
    input  start, abort, rate, length, in_valid, dec_valid, dec_bit,
    output in_ready, sym_start, n_cbps, num_pads, out_bit, out_valid,
    output busy, done, rate_err, service
  );
`else
  modport master (
    output start, abort, rate, length, in_valid, dec_valid, dec_bit,
    input  in_ready, sym_start, n_cbps, num_pads, out_bit, out_valid,
    input  busy, done, rate_err
  );

  modport slave (
    input  start, abort, rate, length, in_valid, dec_valid, dec_bit,
    output in_ready, sym_start, n_cbps, num_pads, out_bit, out_valid,
    output busy, done, rate_err
  );
`endif
endinterface

// File: rtl/rx_frame_ctrl.sv
// 802.11a DATA-field sequencer: symbol/pad arithmetic, coded-symbol framing and PSDU gating.
// Optional SERVICE-field capture is built when RX_SERVICE_CAPTURE_EN is defined.
module rx_frame_ctrl #(
  parameter int LEN_W = 12,
  parameter int PAD_W = 8,
  parameter int CNT_W = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rx_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // {supported, N_CBPS, N_DBPS}
  function automatic logic [17:0] rate_lookup(input logic [3:0] rate);
    case (rate)
      4'b1101: rate_lookup = {1'b1, 9'd48,  8'd24};
      4'b1111: rate_lookup = {1'b1, 9'd48,  8'd36};
      4'b0101: rate_lookup = {1'b1, 9'd96,  8'd48};
      4'b0111: rate_lookup = {1'b1, 9'd96,  8'd72};
      4'b1001: rate_lookup = {1'b1, 9'd192, 8'd96};
      4'b1011: rate_lookup = {1'b1, 9'd192, 8'd144};
      4'b0001: rate_lookup = {1'b1, 9'd288, 8'd192};
      4'b0011: rate_lookup = {1'b1, 9'd288, 8'd216};
      default: rate_lookup = {1'b0, 9'd0,   8'd0};
    endcase
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [8:0]       r_n_cbps;
  logic [7:0]       r_n_dbps;
  logic [CNT_W-1:0] r_ndata;
  logic [CNT_W-1:0] r_psdu_end;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_nsym;
  logic [8:0]       r_coded_cnt;
  logic [CNT_W-1:0] r_coded_sym;
  logic [CNT_W-1:0] r_dec_cnt;
  logic [PAD_W-1:0] r_num_pads;
  logic             r_out_bit;
  logic             r_out_valid;
  logic             r_done;
  logic             r_rate_err;

  logic [17:0]      w_lut;
  logic [LEN_W+2:0] w_len_x8;
  logic             w_rate_ok;
  logic             w_calc_done;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_dec_fire;
  logic [CNT_W-1:0] w_dec_next;
  logic             w_in_psdu;

  assign w_lut       = rate_lookup(bus.rate);
  assign w_len_x8    = {bus.length, 3'b000};
  assign w_rate_ok   = w_lut[17] && (bus.length != {LEN_W{1'b0}});
  // At the end of CALC, r_acc holds N_SYM*N_DBPS, the total decoded bit count.
  assign w_calc_done = (r_acc >= r_ndata);
  assign w_in_ready  = (r_state == ST_RUN) && (r_coded_sym < r_nsym);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_dec_fire  = (r_state == ST_RUN) && bus.dec_valid;
  assign w_dec_next  = r_dec_cnt + CNT_W'(1);
  assign w_in_psdu   = (r_dec_cnt >= CNT_W'(16)) && (r_dec_cnt < r_psdu_end);

  assign bus.in_ready  = w_in_ready;
  assign bus.sym_start = w_accept && (r_coded_cnt == 9'd0);
  assign bus.n_cbps    = r_n_cbps;
  assign bus.num_pads  = r_num_pads;
  assign bus.out_bit   = r_out_bit;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.rate_err  = r_rate_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && w_rate_ok) begin
            w_next = ST_CALC;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (w_calc_done) begin
            w_next = ST_RUN;
          end else begin
            w_next = ST_CALC;
          end
        end
        ST_RUN: begin
          if (w_dec_fire && (w_dec_next == r_acc)) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_RUN;
          end
        end
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_n_cbps    <= 9'd0;
      r_n_dbps    <= 8'd0;
      r_ndata     <= {CNT_W{1'b0}};
      r_psdu_end  <= {CNT_W{1'b0}};
      r_acc       <= {CNT_W{1'b0}};
      r_nsym      <= {CNT_W{1'b0}};
      r_coded_cnt <= 9'd0;
      r_coded_sym <= {CNT_W{1'b0}};
      r_dec_cnt   <= {CNT_W{1'b0}};
      r_num_pads  <= {PAD_W{1'b0}};
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_rate_err  <= 1'b0;
    end else begin
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_rate_err  <= 1'b0;
      if (bus.abort) begin
        r_acc       <= {CNT_W{1'b0}};
        r_nsym      <= {CNT_W{1'b0}};
        r_coded_cnt <= 9'd0;
        r_coded_sym <= {CNT_W{1'b0}};
        r_dec_cnt   <= {CNT_W{1'b0}};
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start && w_rate_ok) begin
              r_n_cbps    <= w_lut[16:8];
              r_n_dbps    <= w_lut[7:0];
              r_ndata     <= CNT_W'(22) + CNT_W'(w_len_x8);
              r_psdu_end  <= CNT_W'(16) + CNT_W'(w_len_x8);
              r_acc       <= {CNT_W{1'b0}};
              r_nsym      <= {CNT_W{1'b0}};
              r_coded_cnt <= 9'd0;
              r_coded_sym <= {CNT_W{1'b0}};
              r_dec_cnt   <= {CNT_W{1'b0}};
            end else if (bus.start) begin
              r_rate_err <= 1'b1;
            end else begin
              r_rate_err <= 1'b0;
            end
          end
          ST_CALC: begin
            if (!w_calc_done) begin
              r_acc  <= r_acc + CNT_W'(r_n_dbps);
              r_nsym <= r_nsym + CNT_W'(1);
            end else begin
              r_num_pads <= PAD_W'(r_acc - r_ndata);
            end
          end
          ST_RUN: begin
            if (w_accept) begin
              if (r_coded_cnt == r_n_cbps - 9'd1) begin
                r_coded_cnt <= 9'd0;
                r_coded_sym <= r_coded_sym + CNT_W'(1);
              end else begin
                r_coded_cnt <= r_coded_cnt + 9'd1;
              end
            end
            if (w_dec_fire) begin
              r_dec_cnt <= w_dec_next;
              if (w_in_psdu) begin
                r_out_valid <= 1'b1;
                r_out_bit   <= bus.dec_bit;
              end
              if (w_dec_next == r_acc) begin
                r_done <= 1'b1;
              end
            end
          end
          ST_DONE: r_done <= 1'b0;
          default: r_done <= 1'b0;
        endcase
      end
    end
  end

`ifdef RX_SERVICE_CAPTURE_EN
  logic [15:0] r_service;

  assign bus.service = r_service;

  // Decoded bits 0..15 are the SERVICE field; bit d lands in service[d].
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.abort) begin
      r_service <= 16'd0;
    end else if ((r_state == ST_IDLE) && bus.start && w_rate_ok) begin
      r_service <= 16'd0;
    end else if (w_dec_fire && (r_dec_cnt < CNT_W'(16))) begin
      r_service[r_dec_cnt[3:0]] <= bus.dec_bit;
    end else begin
      r_service <= r_service;
    end
  end
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: table-driven frames, randomized frames, abort/reset corners.
module tb_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rx_frame_ctrl_if bus ();

  rx_frame_ctrl dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [3:0] rate;
    int         len;
    bit         err;
    int         cbps;
    int         nsym;
    int         pads;
    bit         inj;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: rate table lookup plus ceiling division for N_SYM.
  task automatic model(input logic [3:0] rate, input int len, output int cbps,
                       output int nsym, output int pads, output bit err);
    int dbps;
    case (rate)
      4'b1101: begin cbps = 48;  dbps = 24;  end
      4'b1111: begin cbps = 48;  dbps = 36;  end
      4'b0101: begin cbps = 96;  dbps = 48;  end
      4'b0111: begin cbps = 96;  dbps = 72;  end
      4'b1001: begin cbps = 192; dbps = 96;  end
      4'b1011: begin cbps = 192; dbps = 144; end
      4'b0001: begin cbps = 288; dbps = 192; end
      4'b0011: begin cbps = 288; dbps = 216; end
      default: begin cbps = 0;   dbps = 0;   end
    endcase
    err  = (dbps == 0) || (len == 0);
    nsym = err ? 0 : (22 + 8 * len + dbps - 1) / dbps;
    pads = err ? 0 : nsym * dbps - (22 + 8 * len);
  endtask

  task automatic start_frame(input logic [3:0] rate, input int len);
    logic [11:0] l12;
    l12 = len[11:0];
    @(negedge clk);
    bus.rate   = rate;
    bus.length = l12;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    #1;
  endtask

  task automatic wait_ready(input bit inj, output int cyc);
    cyc = 0;
    while (!bus.in_ready && cyc < 2000) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (inj && cyc == 3) begin
        bus.start  = 1'b1;
        bus.rate   = 4'b0011;
        bus.length = 12'd5;
      end
      #1;
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  // abort_after < 0: full frame; otherwise abort once that many decoded bits were fed.
  task automatic run_frame(input logic [3:0] rate, input int len, input bit e_err, input int e_cbps,
                           input int e_nsym, input int e_pads, input bit inj, input int abort_after);
    int cyc, acc, syms, ss_err, extra, ncoded, total, sent, done_sent, bad;
    bit done_seen, b, exp_ss;
    bit exp_q[$];
    bit got_q[$];
    start_frame(rate, len);
    if (e_err) begin
      chk("rate_err_pulse", bus.rate_err, 1);
      chk("err_busy", bus.busy, 0);
      chk("err_in_ready", bus.in_ready, 0);
      @(negedge clk); #1;
      chk("rate_err_one_cycle", bus.rate_err, 0);
      return;
    end
    chk("busy_after_start", bus.busy, 1);
    chk("calc_in_ready_low", bus.in_ready, 0);
    wait_ready(inj, cyc);
    chk("calc_timeout", (cyc < 2000) ? 1 : 0, 1);
    chk("n_cbps", bus.n_cbps, e_cbps);
    chk("num_pads", bus.num_pads, e_pads);
    ncoded = e_nsym * e_cbps;
    acc = 0; syms = 0; ss_err = 0; extra = 0; cyc = 0;
    while ((acc < ncoded || extra < 8) && cyc < ncoded * 8 + 200) begin
      @(negedge clk);
      bus.start    = (inj && acc == ncoded / 2) ? 1'b1 : 1'b0;
      bus.in_valid = ($urandom_range(0, 3) != 0) || (acc >= ncoded);
      #1;
      exp_ss = bus.in_valid && bus.in_ready && (acc % e_cbps == 0);
      if (bus.sym_start !== exp_ss) ss_err++;
      if (bus.sym_start) syms++;
      if (bus.in_valid && bus.in_ready) acc++;
      if (acc >= ncoded) extra++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("coded_accepted", acc, ncoded);
    chk("sym_start_count", syms, e_nsym);
    chk("sym_start_position_errs", ss_err, 0);
    total = 22 + 8 * len + e_pads;
    sent = 0; done_seen = 1'b0; done_sent = -1; cyc = 0;
    while (!done_seen && cyc < total * 8 + 200) begin
      @(negedge clk);
      if (abort_after >= 0 && sent == abort_after) begin
        bus.dec_valid = 1'b0;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        return;
      end
      b = 1'($urandom_range(0, 1));
      bus.dec_valid = (sent < total) && ($urandom_range(0, 3) != 0);
      bus.dec_bit   = b;
      #1;
      if (bus.out_valid) got_q.push_back(bus.out_bit);
      if (bus.done) begin
        done_seen = 1'b1;
        done_sent = sent;
      end
      if (bus.dec_valid) begin
        if (sent >= 16 && sent < 16 + 8 * len) exp_q.push_back(b);
        sent++;
      end
      cyc++;
    end
    bus.dec_valid = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("done_after_bit", done_sent, total);
    chk("psdu_bit_count", got_q.size(), 8 * len);
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) bad++;
    end
    chk("psdu_bit_errors", bad, 0);
    @(negedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
  endtask

  vec_t vecs[11];

  initial begin
    int cb, ns, pd, ln, cyc;
    bit er;
    logic [3:0] rt;
    logic [3:0] rates[8];

    vecs[0]  = '{4'b1101, 100, 1'b0, 48,  35, 18, 1'b0};
    vecs[1]  = '{4'b0011, 100, 1'b0, 288, 4,  42, 1'b0};
    vecs[2]  = '{4'b1001, 100, 1'b0, 192, 9,  42, 1'b0};
    vecs[3]  = '{4'b0000, 100, 1'b1, 0,   0,  0,  1'b0};
    vecs[4]  = '{4'b0101, 0,   1'b1, 0,   0,  0,  1'b0};
    vecs[5]  = '{4'b1100, 10,  1'b1, 0,   0,  0,  1'b0};
    vecs[6]  = '{4'b1101, 1,   1'b0, 48,  2,  18, 1'b0};
    vecs[7]  = '{4'b0111, 1,   1'b0, 96,  1,  42, 1'b0};
    vecs[8]  = '{4'b1011, 50,  1'b0, 192, 3,  10, 1'b0};
    vecs[9]  = '{4'b0001, 7,   1'b0, 288, 1,  114, 1'b0};
    vecs[10] = '{4'b1101, 100, 1'b0, 48,  35, 18, 1'b1};
    rates = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0001, 4'b0011};

    bus.start = 1'b0; bus.abort = 1'b0; bus.rate = 4'b0000; bus.length = 12'd0;
    bus.in_valid = 1'b0; bus.dec_valid = 1'b0; bus.dec_bit = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_n_cbps", bus.n_cbps, 0);
    chk("rst_num_pads", bus.num_pads, 0);
    chk("rst_rate_err", bus.rate_err, 0);

    foreach (vecs[i]) begin
      run_frame(vecs[i].rate, vecs[i].len, vecs[i].err, vecs[i].cbps,
                vecs[i].nsym, vecs[i].pads, vecs[i].inj, -1);
    end

    for (int k = 0; k < 4; k++) begin
      rt = rates[$urandom_range(0, 7)];
      ln = $urandom_range(1, 120);
      model(rt, ln, cb, ns, pd, er);
      run_frame(rt, ln, er, cb, ns, pd, 1'b0, -1);
    end

    // Abort after 500 decoded bits, then an immediate clean frame.
    run_frame(4'b1101, 100, 1'b0, 48, 35, 18, 1'b0, 500);
    run_frame(4'b1101, 100, 1'b0, 48, 35, 18, 1'b0, -1);

    // Abort and start together from IDLE: abort wins.
    @(negedge clk);
    bus.rate = 4'b1101; bus.length = 12'd100; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    #1;
    chk("abort_start_busy", bus.busy, 0);
    chk("abort_start_rate_err", bus.rate_err, 0);

    // Reset in the middle of RUN clears state and outputs.
    start_frame(4'b1001, 100);
    wait_ready(1'b0, cyc);
    chk("mid_reset_reach_run", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_reset_busy", bus.busy, 0);
    chk("mid_reset_n_cbps", bus.n_cbps, 0);
    chk("mid_reset_num_pads", bus.num_pads, 0);
    chk("mid_reset_in_ready", bus.in_ready, 0);

    run_frame(4'b0011, 100, 1'b0, 288, 4, 42, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
